// File: rtl/tm_inference_pkg.sv
// Shared types and constants for the inference result path: default batch geometry,
// marker words and the result-writer state encoding.
package tm_inference_pkg;

    localparam int CLASS_LEN = 4;
    localparam int IMAGES    = 8;

    localparam logic [31:0] DONE_MARK   = 32'hFFFF_FF01;
    localparam logic [31:0] END_MARK    = 32'hFFFF_FFFF;
    localparam logic [31:0] RESULT_MARK = 32'hFFFF_FF00;

    typedef logic [CLASS_LEN-1:0] class_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        MARK,
        DONE
    } wr_state_t;

    // Number of 32-bit words needed to hold a batch of packed classes.
    function automatic int words_for(input int images, input int class_len);
        return (images * class_len + 31) / 32;
    endfunction

endpackage

// File: rtl/class_word_packer.sv
// Flattens an IMAGES x CLASS_LEN class array into WORDS 32-bit words, image 0 in the
// least significant bits, with unused upper bits forced to zero.
module class_word_packer
    import tm_inference_pkg::*;
#(
    parameter int CLASS_LEN = tm_inference_pkg::CLASS_LEN,
    parameter int IMAGES    = tm_inference_pkg::IMAGES,
    parameter int WORDS     = words_for(IMAGES, CLASS_LEN)
) (
    input  logic [IMAGES-1:0][CLASS_LEN-1:0] classes,
    output logic [WORDS-1:0][31:0]           words
);

    localparam int USED_BITS  = IMAGES * CLASS_LEN;
    localparam int TOTAL_BITS = WORDS * 32;

    logic [TOTAL_BITS-1:0] flat;

    generate
        for (genvar gi = 0; gi < IMAGES; gi++) begin : g_image
            assign flat[CLASS_LEN*gi +: CLASS_LEN] = classes[gi];
        end
        if (TOTAL_BITS > USED_BITS) begin : g_pad
            assign flat[TOTAL_BITS-1:USED_BITS] = '0;
        end
    endgenerate

    assign words = flat;

endmodule

// File: rtl/inference_result_writer.sv
// Snapshots a batch of predicted classes on each result_ready rising edge and writes the
// packed words, followed by a completion marker, into a BRAM result region.
module inference_result_writer
    import tm_inference_pkg::*;
#(
    parameter int          CLASS_LEN = tm_inference_pkg::CLASS_LEN,
    parameter int          IMAGES    = tm_inference_pkg::IMAGES,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] DONE_MARK = tm_inference_pkg::DONE_MARK
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             start,
    input  logic                             result_ready,
    input  logic [IMAGES-1:0][CLASS_LEN-1:0] predicted_class,
    output logic [31:0]                      addra,
    output logic [31:0]                      dina,
    output logic                             ena,
    output logic [3:0]                       wea,
    output logic                             busy,
    output logic                             done
);

    localparam int          WORDS     = words_for(IMAGES, CLASS_LEN);
    localparam logic [31:0] LAST_K    = 32'(WORDS - 1);
    localparam logic [31:0] MARK_ADDR = BASE_ADDR + 32'(4 * WORDS);

    wr_state_t              state_reg;
    logic                   rdy_q_reg;
    logic [31:0]            k_reg;
    logic [WORDS-1:0][31:0] snap_reg;

    logic [WORDS-1:0][31:0] packed_words;
    logic [31:0]            k_next;
    logic [31:0]            next_word;
    logic                   trigger;

    class_word_packer #(
        .CLASS_LEN (CLASS_LEN),
        .IMAGES    (IMAGES),
        .WORDS     (WORDS)
    ) u_packer (
        .classes (predicted_class),
        .words   (packed_words)
    );

    assign trigger = result_ready & ~rdy_q_reg & start;
    assign k_next  = k_reg + 32'd1;

    // Word that follows the one currently on the port, taken from the frozen snapshot.
    always_comb begin
        next_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (k_next == 32'(w)) begin
                next_word = snap_reg[w];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            rdy_q_reg <= 1'b0;
            k_reg     <= '0;
            snap_reg  <= '0;
            addra     <= '0;
            dina      <= '0;
            ena       <= 1'b0;
            wea       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rdy_q_reg <= result_ready;
            if (!start) begin
                // Abandon any sequence in flight; the marker is never written.
                state_reg <= IDLE;
                ena       <= 1'b0;
                wea       <= '0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (trigger) begin
                            snap_reg  <= packed_words;
                            k_reg     <= '0;
                            addra     <= BASE_ADDR;
                            dina      <= packed_words[0];
                            ena       <= 1'b1;
                            wea       <= 4'hF;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            state_reg <= WRITE;
                        end
                    end
                    WRITE: begin
                        // k_reg is the word currently on the port.
                        if (k_reg == LAST_K) begin
                            addra     <= MARK_ADDR;
                            dina      <= DONE_MARK;
                            state_reg <= MARK;
                        end else begin
                            k_reg <= k_next;
                            addra <= BASE_ADDR + (k_next << 2);
                            dina  <= next_word;
                        end
                    end
                    MARK: begin
                        ena       <= 1'b0;
                        wea       <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
